pipe_tag_tracker: RTL and testbench
===================================

Name: pipe_tag_tracker

Overview:
- Parametrised verification-side transaction tag tracker for the riscv_core pipeline. Instantiated beside the core in the top-level wrapper.
- Stage 0 issues a new wrapping tag on each advance. Every later stage copies its predecessor's tag and valid bit when that stage advances.
- Generalises the fixed five-stage tag counters: configurable stage count and tag width, per-stage flush, valid tracking, retire strobe and count, sticky ordering and lost-transaction checkers.

Parameters:
- STAGES, 5, number of pipeline stages tracked (IF..WB); legal range 2..16.
- TAG_W, 6, tag width in bits; tags wrap modulo 2^TAG_W.
- CNT_W, 32, retire counter width.

Ports:
- rstn  input  1  asynchronous active-low reset.
- clk  input  1  clock; all state updates on rising edge.
- stage_inc  input  STAGES  per-stage advance; bit i mirrors the core's stage-i register enable.
- stage_flush  input  STAGES  per-stage kill; bit i invalidates stage i.
- clr  input  1  synchronous clear of retire_cnt, order_err, lost_err and ordering history.
- stage_tag  output  STAGES*TAG_W  tag of stage i in bits [i*TAG_W +: TAG_W].
- stage_vld  output  STAGES  stage i holds a live transaction.
- occupancy  output  $clog2(STAGES+1)  population count of stage_vld (combinational from registers).
- retire_strb  output  1  one-cycle pulse: a valid transaction entered the last stage.
- retire_tag  output  TAG_W  tag that retired; held until the next retire.
- retire_cnt  output  CNT_W  number of retirements, wrapping.
- order_err  output  1  sticky: a retire was out of order or duplicated.
- lost_err  output  1  sticky: a valid transaction was overwritten before it advanced.

Behaviour:
- Reset (rstn=0, asynchronous): all tags 0, stage_vld 0, retire_strb 0, retire_tag 0, retire_cnt 0, order_err 0, lost_err 0, last_tag 0, seen_ret 0. Reset mid-operation discards all in-flight state immediately.
- L = STAGES-1. All reads below use pre-edge register values.
- Stage 0 on stage_inc[0]:
  - tag[0] <= tag[0]+1 (mod 2^TAG_W).
  - vld[0] <= ~stage_flush[0].
- Stage i>0 on stage_inc[i]:
  - tag[i] <= tag[i-1].
  - vld[i] <= vld[i-1] & ~stage_flush[i].
  - Stage i samples the pre-edge vld[i-1]; a simultaneous stage_flush[i-1] does not affect what stage i captures.
- stage_flush[i] without stage_inc[i]: vld[i] <= 0 and the tag is held.
- Flush has priority over inc for vld. The tag update still occurs.
- No inc and no flush: the stage holds its tag and valid bit.
- Lost check for i<L: stage_inc[i] & vld[i] & ~stage_inc[i+1] & ~stage_flush[i] sets lost_err. Overwriting the last stage is normal retirement.
- Retire event R = stage_inc[L] & vld[L-1] & ~stage_flush[L].
  - retire_strb <= R.
  - On R: retire_tag <= tag[L-1], retire_cnt <= retire_cnt+1.
  - retire_strb is high in the same cycle stage_vld[L] first shows the new transaction. Latency from stage-0 issue to retire_strb is exactly the number of subsequent advance edges.
- Ordering check on R when seen_ret=1:
  - d = tag[L-1] - last_tag (TAG_W-bit, unsigned wrap).
  - Error if d==0 or d >= 2^(TAG_W-1); sets order_err at the same edge as retire_strb.
  - Gaps caused by flushes (d>1) are legal.
- On every R: last_tag <= tag[L-1] and seen_ret <= 1. The first retire after reset or clr is never checked.
- clr:
  - Zeroes retire_cnt, order_err, lost_err and seen_ret.
  - Does not touch tags, valids, retire_tag or retire_strb.
  - clr and R in the same cycle: clr wins for retire_cnt and the error flags, but seen_ret <= 1 and last_tag is updated.
- order_err and lost_err are sticky until reset or clr.

Test Plan:
- Issue/advance: STAGES=5, TAG_W=6; pulse stage_inc[0], then inc[1]..inc[4] on successive cycles -> tag 1 walks stages 0..4; retire_strb high once with retire_tag=1, retire_cnt=1; occupancy 1 throughout.
- Wrap: 70 back-to-back issues with all stages advancing every cycle -> retire_tag sequence ..63,0,1..; order_err stays 0; retire_cnt=66 after 70 cycles.
- Flush gap: stage_flush[2] in the cycle tag 3 sits in stage 2 -> tag 3 never retires; retires show 2 then 4; order_err=0; retire_cnt one lower than issued.
- Lost: vld[1]=1 and stage_inc[1]=1 with stage_inc[2]=0 -> lost_err=1 next cycle; clr -> lost_err=0.
- Duplicate: advance stage 4 twice while stage 3 holds tag 5 -> second retire of tag 5 sets order_err=1 in the same cycle as retire_strb.
- Async reset: drop rstn mid-flight with occupancy 4 -> all outputs 0 immediately without a clock edge; the first retire afterwards is not checked.

Source files
------------

// File: rtl/pipe_tag_tracker_if.sv
// Bundle of pipe_tag_tracker control inputs and observation outputs.
// The master drives advance/flush/clear; the slave (tracker) drives tags and status.
interface pipe_tag_tracker_if #(
  parameter int STAGES = 5,
  parameter int TAG_W  = 6,
  parameter int CNT_W  = 32
);
  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0]       stage_inc;
  logic [STAGES-1:0]       stage_flush;
  logic                    clr;
  logic [STAGES*TAG_W-1:0] stage_tag;
  logic [STAGES-1:0]       stage_vld;
  logic [OCC_W-1:0]        occupancy;
  logic                    retire_strb;
  logic [TAG_W-1:0]        retire_tag;
  logic [CNT_W-1:0]        retire_cnt;
  logic                    order_err;
  logic                    lost_err;

  modport master (
    output stage_inc, stage_flush, clr,
    input  stage_tag, stage_vld, occupancy, retire_strb, retire_tag,
           retire_cnt, order_err, lost_err
  );

  modport slave (
    input  stage_inc, stage_flush, clr,
    output stage_tag, stage_vld, occupancy, retire_strb, retire_tag,
           retire_cnt, order_err, lost_err
  );
endinterface

// File: rtl/pipe_tag_tracker.sv
// Transaction tag tracker shadowing the core pipeline: per-stage tag/valid,
// retire strobe/count, and sticky ordering and lost-transaction checkers.
module pipe_tag_stage #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_inc,
  input  logic             i_flush,
  input  logic [TAG_W-1:0] i_nxt_tag,
  input  logic             i_nxt_vld,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_vld
);
  logic [TAG_W-1:0] r_tag;
  logic             r_vld;

  // Flush wins over advance for the valid bit, but the tag still moves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tag <= '0;
      r_vld <= 1'b0;
    end else if (i_inc) begin
      r_tag <= i_nxt_tag;
      r_vld <= i_nxt_vld & ~i_flush;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end
  end

  assign o_tag = r_tag;
  assign o_vld = r_vld;
endmodule

module pipe_tag_tracker #(
  parameter int STAGES = 5,
  parameter int TAG_W  = 6,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  pipe_tag_tracker_if.slave bus
);
  localparam int L     = STAGES-1;
  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0][TAG_W-1:0] w_tag;
  logic [STAGES-1:0][TAG_W-1:0] w_nxt_tag;
  logic [STAGES-1:0]            w_nxt_vld;
  logic [STAGES-1:0]            w_vld;
  logic [OCC_W-1:0]             w_occ;
  logic [TAG_W-1:0]             w_d;
  logic                         w_ret;
  logic                         w_lost;
  logic                         w_ord_bad;

  logic                         r_strb;
  logic [TAG_W-1:0]             r_rtag;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_order_err;
  logic                         r_lost_err;
  logic [TAG_W-1:0]             r_last_tag;
  logic                         r_seen;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign w_nxt_tag[i] = w_tag[0] + TAG_W'(1);
      assign w_nxt_vld[i] = 1'b1;
    end else begin : g_body
      assign w_nxt_tag[i] = w_tag[i-1];
      assign w_nxt_vld[i] = w_vld[i-1];
    end

    pipe_tag_stage #(.TAG_W(TAG_W)) u_stg (
      .clk       (clk),
      .rstn      (rstn),
      .i_inc     (bus.stage_inc[i]),
      .i_flush   (bus.stage_flush[i]),
      .i_nxt_tag (w_nxt_tag[i]),
      .i_nxt_vld (w_nxt_vld[i]),
      .o_tag     (w_tag[i]),
      .o_vld     (w_vld[i])
    );
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < STAGES; i++) w_occ = w_occ + OCC_W'(w_vld[i]);
  end

  // A live stage that is overwritten while its successor stalls loses a transaction.
  assign w_lost = |(bus.stage_inc[L-1:0] & w_vld[L-1:0] &
                    ~bus.stage_inc[L:1] & ~bus.stage_flush[L-1:0]);

  assign w_ret     = bus.stage_inc[L] & w_vld[L-1] & ~bus.stage_flush[L];
  assign w_d       = w_tag[L-1] - r_last_tag;
  // Tags must move forward by less than half the tag space; flush gaps are fine.
  assign w_ord_bad = w_ret & r_seen & ((w_d == '0) | w_d[TAG_W-1]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_strb      <= 1'b0;
      r_rtag      <= '0;
      r_cnt       <= '0;
      r_order_err <= 1'b0;
      r_lost_err  <= 1'b0;
      r_last_tag  <= '0;
      r_seen      <= 1'b0;
    end else begin
      r_strb <= w_ret;
      if (w_ret) begin
        r_rtag     <= w_tag[L-1];
        r_last_tag <= w_tag[L-1];
        r_seen     <= 1'b1;
      end else if (bus.clr) begin
        r_seen     <= 1'b0;
      end
      if (bus.clr) begin
        r_cnt       <= '0;
        r_order_err <= 1'b0;
        r_lost_err  <= 1'b0;
      end else begin
        if (w_ret)     r_cnt       <= r_cnt + CNT_W'(1);
        if (w_ord_bad) r_order_err <= 1'b1;
        if (w_lost)    r_lost_err  <= 1'b1;
      end
    end
  end

  assign bus.stage_tag   = w_tag;
  assign bus.stage_vld   = w_vld;
  assign bus.occupancy   = w_occ;
  assign bus.retire_strb = r_strb;
  assign bus.retire_tag  = r_rtag;
  assign bus.retire_cnt  = r_cnt;
  assign bus.order_err   = r_order_err;
  assign bus.lost_err    = r_lost_err;
endmodule

// File: tb/tb_pipe_tag_tracker.sv
// Bench for pipe_tag_tracker (STAGES=5, TAG_W=6): vector table, retire
// scoreboard and hand-written multi-cycle corner sequences.
module tb_pipe_tag_tracker;
  localparam int STAGES = 5;
  localparam int TAG_W  = 6;
  localparam int CNT_W  = 32;

  typedef struct {
    logic [4:0]  inc;
    logic [4:0]  fl;
    logic [29:0] tags;
    logic [4:0]  vld;
    logic [2:0]  occ;
    logic        strb;
    logic [5:0]  rtag;
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [5:0] issue_tag;
  logic [5:0] sb_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  pipe_tag_tracker_if #(.STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  pipe_tag_tracker #(.STAGES(STAGES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic logic [29:0] tg(input logic [5:0] t4, t3, t2, t1, t0);
    return {t4, t3, t2, t1, t0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [4:0] inc, input logic [4:0] fl, input logic c);
    bus.stage_inc = inc; bus.stage_flush = fl; bus.clr = c;
    @(posedge clk); #1;
    bus.stage_inc = '0; bus.stage_flush = '0; bus.clr = 1'b0;
  endtask

  task automatic sb_check();
    if (bus.retire_strb) begin
      if (sb_q.size() == 0) chk("sb_unexpected_retire", 64'(bus.retire_tag), 64'hdead);
      else chk("sb_rtag", 64'(bus.retire_tag), 64'(sb_q.pop_front()));
    end
  endtask

  // All stages advance; the newly issued tag is queued unless it is known to die.
  task automatic stream(input logic [4:0] fl, input logic skip);
    issue_tag = issue_tag + 6'd1;
    if (!fl[0] && !skip) sb_q.push_back(issue_tag);
    cyc(5'b11111, fl, 1'b0);
    sb_check();
  endtask

  task automatic do_reset();
    rstn = 1'b0; #3; rstn = 1'b1;
    sb_q.delete();
    issue_tag = '0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_tags"}, 64'(bus.stage_tag), 64'd0);
    chk({nm, "_vld"},  64'(bus.stage_vld), 64'd0);
    chk({nm, "_occ"},  64'(bus.occupancy), 64'd0);
    chk({nm, "_strb"}, 64'(bus.retire_strb), 64'd0);
    chk({nm, "_rtag"}, 64'(bus.retire_tag), 64'd0);
    chk({nm, "_cnt"},  64'(bus.retire_cnt), 64'd0);
    chk({nm, "_oerr"}, 64'(bus.order_err), 64'd0);
    chk({nm, "_lerr"}, 64'(bus.lost_err), 64'd0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.stage_inc = '0; bus.stage_flush = '0; bus.clr = 1'b0;
    issue_tag = '0;

    // Single transaction walked by hand, upstream stage flushed behind it.
    tbl[0] = '{5'b00001, 5'b00000, tg(0,0,0,0,1), 5'b00001, 3'd1, 1'b0, 6'd0, 32'd0};
    tbl[1] = '{5'b00010, 5'b00001, tg(0,0,0,1,1), 5'b00010, 3'd1, 1'b0, 6'd0, 32'd0};
    tbl[2] = '{5'b00100, 5'b00010, tg(0,0,1,1,1), 5'b00100, 3'd1, 1'b0, 6'd0, 32'd0};
    tbl[3] = '{5'b01000, 5'b00100, tg(0,1,1,1,1), 5'b01000, 3'd1, 1'b0, 6'd0, 32'd0};
    tbl[4] = '{5'b10000, 5'b01000, tg(1,1,1,1,1), 5'b10000, 3'd1, 1'b1, 6'd1, 32'd1};
    tbl[5] = '{5'b00000, 5'b00000, tg(1,1,1,1,1), 5'b10000, 3'd1, 1'b0, 6'd1, 32'd1};
    tbl[6] = '{5'b00000, 5'b10000, tg(1,1,1,1,1), 5'b00000, 3'd0, 1'b0, 6'd1, 32'd1};
    tbl[7] = '{5'b00001, 5'b00001, tg(1,1,1,1,2), 5'b00000, 3'd0, 1'b0, 6'd1, 32'd1};

    @(posedge clk); #1;
    do_reset();
    chk_zero("reset");

    foreach (tbl[k]) begin
      cyc(tbl[k].inc, tbl[k].fl, 1'b0);
      chk($sformatf("v%0d_tags", k), 64'(bus.stage_tag), 64'(tbl[k].tags));
      chk($sformatf("v%0d_vld", k),  64'(bus.stage_vld), 64'(tbl[k].vld));
      chk($sformatf("v%0d_occ", k),  64'(bus.occupancy), 64'(tbl[k].occ));
      chk($sformatf("v%0d_strb", k), 64'(bus.retire_strb), 64'(tbl[k].strb));
      chk($sformatf("v%0d_rtag", k), 64'(bus.retire_tag), 64'(tbl[k].rtag));
      chk($sformatf("v%0d_cnt", k),  64'(bus.retire_cnt), 64'(tbl[k].cnt));
    end
    chk("walk_oerr", 64'(bus.order_err), 64'd0);
    chk("walk_lerr", 64'(bus.lost_err), 64'd0);

    // Wrap: 70 back-to-back issues, retires pass through 63 -> 0.
    do_reset();
    for (int j = 0; j < 70; j++) stream(5'b00000, 1'b0);
    chk("wrap_cnt", 64'(bus.retire_cnt), 64'd66);
    chk("wrap_oerr", 64'(bus.order_err), 64'd0);
    chk("wrap_lerr", 64'(bus.lost_err), 64'd0);
    chk("wrap_pending", 64'(sb_q.size()), 64'd4);

    // Flush gap: tag 3 is killed as it enters stage 2; retires go 2 -> 4.
    do_reset();
    for (int j = 0; j < 10; j++) stream((j == 4) ? 5'b00100 : 5'b00000, j == 2);
    chk("gap_cnt", 64'(bus.retire_cnt), 64'd5);
    chk("gap_oerr", 64'(bus.order_err), 64'd0);

    // Lost: stage 1 overwritten while stage 2 stalls, then cleared.
    do_reset();
    cyc(5'b00001, 5'b00000, 1'b0);
    cyc(5'b00010, 5'b00000, 1'b0);
    chk("lost_pre", 64'(bus.lost_err), 64'd0);
    cyc(5'b00010, 5'b00000, 1'b0);
    chk("lost_set", 64'(bus.lost_err), 64'd1);
    cyc(5'b00000, 5'b00000, 1'b0);
    chk("lost_sticky", 64'(bus.lost_err), 64'd1);
    cyc(5'b00000, 5'b00000, 1'b1);
    chk("lost_clr", 64'(bus.lost_err), 64'd0);

    // Duplicate retire of tag 5, then clr / clr-with-retire interplay.
    do_reset();
    for (int j = 0; j < 8; j++) stream(5'b00000, 1'b0);
    sb_q.delete();
    cyc(5'b10000, 5'b00000, 1'b0);
    chk("dup1_strb", 64'(bus.retire_strb), 64'd1);
    chk("dup1_rtag", 64'(bus.retire_tag), 64'd5);
    chk("dup1_oerr", 64'(bus.order_err), 64'd0);
    chk("dup1_cnt", 64'(bus.retire_cnt), 64'd5);
    cyc(5'b10000, 5'b00000, 1'b0);
    chk("dup2_strb", 64'(bus.retire_strb), 64'd1);
    chk("dup2_oerr", 64'(bus.order_err), 64'd1);
    chk("dup2_cnt", 64'(bus.retire_cnt), 64'd6);
    cyc(5'b00000, 5'b00000, 1'b1);
    chk("clr_oerr", 64'(bus.order_err), 64'd0);
    chk("clr_cnt", 64'(bus.retire_cnt), 64'd0);
    chk("clr_rtag", 64'(bus.retire_tag), 64'd5);
    cyc(5'b10000, 5'b00000, 1'b0);
    chk("unchk_oerr", 64'(bus.order_err), 64'd0);
    chk("unchk_cnt", 64'(bus.retire_cnt), 64'd1);
    cyc(5'b10000, 5'b00000, 1'b1);
    chk("clrret_strb", 64'(bus.retire_strb), 64'd1);
    chk("clrret_cnt", 64'(bus.retire_cnt), 64'd0);
    chk("clrret_oerr", 64'(bus.order_err), 64'd0);
    cyc(5'b10000, 5'b00000, 1'b0);
    chk("seen_oerr", 64'(bus.order_err), 64'd1);
    chk("seen_cnt", 64'(bus.retire_cnt), 64'd1);
    cyc(5'b00000, 5'b10000, 1'b0);
    chk("pre_rst_occ", 64'(bus.occupancy), 64'd4);

    // Async reset mid-flight, away from any clock edge.
    #2 rstn = 1'b0;
    #1 chk_zero("async");
    rstn = 1'b1;
    sb_q.delete();
    issue_tag = '0;
    @(posedge clk); #1;

    // First retire after reset is tag 40 (d=40 from 0) and must not be checked.
    for (int j = 0; j < 39; j++) stream(5'b00001, 1'b0);
    for (int j = 0; j < 6; j++) stream(5'b00000, 1'b0);
    chk("post_rst_cnt", 64'(bus.retire_cnt), 64'd2);
    chk("post_rst_oerr", 64'(bus.order_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
